// File: rtl/uart_mem_loader.sv
// UART firmware loader: receives SYNC, ADDR, COUNT and data words and writes them to the data bus.
// Define UART_MEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
`timescale 1ns/1ps
module uart_mem_loader #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            uart_rx,
    output logic            bus_req,
    input  logic            bus_gnt,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_we,
    output logic            core_hold,
    output logic            done,
    output logic            err,
    output logic            busy
);

    localparam int unsigned    CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_WRITE, S_CSUM, S_FINISH
    } state_t;

`ifdef UART_MEM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_FINISH;
`endif

    logic rx_meta, rx_sync, rx_prev;

    // NOTE: non-blocking assignments make each flop sample the previous stage's old value,
    // which is what builds the two-stage synchroniser chain; blocking would collapse it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_valid;
    logic             rx_ferr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Line back high at mid-start means a glitch, not a start bit.
                    if (rx_cnt == HALF_BIT) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == FULL_BIT) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == FULL_BIT) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        rx_valid <= rx_sync;
                        rx_ferr  <= !rx_sync;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [15:0] remaining;
    logic        abort;

    // Framing errors mid-frame and bytes arriving before a pending write drains both kill the frame.
    assign abort = (rx_ferr && state != S_IDLE) || (rx_valid && state == S_WRITE);

`ifdef UART_MEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
        end else if (state == S_IDLE) begin
            csum <= '0;
        end else if (rx_valid && (state == S_ADDR || state == S_LEN || state == S_DATA)) begin
            csum <= csum ^ rx_shift;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            byte_cnt  <= '0;
            remaining <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 4'h0;
            core_hold <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= S_IDLE;
                bus_req   <= 1'b0;
                bus_we    <= 4'h0;
                core_hold <= 1'b0;
                busy      <= 1'b0;
                err       <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rx_valid && rx_shift == SYNC_BYTE) begin
                            state     <= S_ADDR;
                            byte_cnt  <= '0;
                            err       <= 1'b0;
                            core_hold <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        if (rx_valid) begin
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                bus_addr <= {rx_shift, bus_addr[XLEN-1:10], 2'b00};
                                state    <= S_LEN;
                            end else begin
                                bus_addr <= {rx_shift, bus_addr[XLEN-1:8]};
                            end
                        end
                    end
                    S_LEN: begin
                        if (rx_valid) begin
                            remaining <= {rx_shift, remaining[15:8]};
                            byte_cnt  <= byte_cnt + 2'd1;
                            if (byte_cnt[0]) begin
                                byte_cnt <= '0;
                                state    <= ({rx_shift, remaining[15:8]} == 16'd0) ? S_TAIL : S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (rx_valid) begin
                            bus_wdata <= {rx_shift, bus_wdata[XLEN-1:8]};
                            byte_cnt  <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                state   <= S_WRITE;
                                bus_req <= 1'b1;
                                bus_we  <= 4'hF;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (bus_gnt) begin
                            bus_req   <= 1'b0;
                            bus_we    <= 4'h0;
                            bus_addr  <= bus_addr + XLEN'(4);
                            remaining <= remaining - 16'd1;
                            state     <= (remaining == 16'd1) ? S_TAIL : S_DATA;
                        end
                    end
`ifdef UART_MEM_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (rx_valid) begin
                            if (rx_shift == csum) begin
                                state <= S_FINISH;
                            end else begin
                                state     <= S_IDLE;
                                core_hold <= 1'b0;
                                busy      <= 1'b0;
                                err       <= 1'b1;
                            end
                        end
                    end
`endif
                    S_FINISH: begin
                        done      <= 1'b1;
                        core_hold <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader: frames are built from field values, expected writes
// come from address/word arithmetic, and one negedge monitor checks every bus cycle.
`timescale 1ns/1ps
module tb_uart_mem_loader;

    localparam int         XLEN = 32;
    localparam int         CPB  = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            uart_rx = 1'b1;
    logic            bus_gnt = 1'b1;
    logic            bus_req;
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic [3:0]      bus_we;
    logic            core_hold;
    logic            done;
    logic            err;
    logic            busy;

    always #5 clk = ~clk;

    uart_mem_loader #(.XLEN(XLEN), .CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .core_hold(core_hold), .done(done), .err(err), .busy(busy)
    );

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    wr_t exp_q[$];
    wr_t log_q[$];
    int  done_cnt = 0;
    int  stall_once = 0;
    bit  rand_stall = 0;
    int  stall_left = 0;
    int  stall_applied = 0;
    int  req_cycles = 0;
    bit  req_prev = 0;
    bit  stalled_prev = 0;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_we;
    wr_t mon_e;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    bit  csum_corrupt = 0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus monitor and grant driver: every write is checked against the expected-write queue.
    always @(negedge clk) begin
        if (rst) begin
            bus_gnt      = 1'b1;
            stall_left   = 0;
            req_prev     = 0;
            stalled_prev = 0;
            req_cycles   = 0;
        end else begin
            if (done) begin
                done_cnt++;
                check("err_with_done", err, 0);
            end
            if (bus_req || bus_we != 4'h0) begin
                check("we_vs_req", {27'b0, bus_req, bus_we}, 32'h1F);
                check("addr_align", bus_addr[1:0], 0);
                check("hold_in_write", core_hold, 1);
            end
            if (stalled_prev) begin
                check("stall_req", bus_req, 1);
                check("stall_addr", bus_addr, prev_addr);
                check("stall_wdata", bus_wdata, prev_wdata);
                check("stall_we", bus_we, prev_we);
            end
            if (bus_req && !req_prev) begin
                stall_left = stall_once;
                stall_once = 0;
                if (rand_stall) stall_left += $urandom_range(0, 3);
                stall_applied = stall_left;
                req_cycles = 0;
            end
            if (bus_req) req_cycles++;
            if (bus_req && stall_left > 0) begin
                bus_gnt = 1'b0;
                stall_left--;
            end else begin
                bus_gnt = 1'b1;
            end
            stalled_prev = bus_req && !bus_gnt;
            prev_addr    = bus_addr;
            prev_wdata   = bus_wdata;
            prev_we      = bus_we;
            if (bus_req && bus_gnt) begin
                log_q.push_back({bus_addr, bus_wdata});
                check("req_cycles", req_cycles, stall_applied + 1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got %h @ %h, expected no write", bus_wdata, bus_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", bus_addr, mon_e.addr);
                    check("wr_data", bus_wdata, mon_e.data);
                end
            end
            req_prev = bus_req;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_ok;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_junk();
        logic [7:0] j;
        do j = 8'($urandom); while (j == SYNC);
        send_byte(j);
    endtask

    task automatic send_frame(input logic [31:0] addr, input logic [31:0] words[$]);
        logic [7:0]  body[$];
        logic [15:0] cnt;
        logic [31:0] a;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
        logic [7:0]  csum;
`endif
        cnt = 16'(words.size());
        for (int i = 0; i < 4; i++) body.push_back(addr[8*i +: 8]);
        body.push_back(cnt[7:0]);
        body.push_back(cnt[15:8]);
        foreach (words[i]) for (int k = 0; k < 4; k++) body.push_back(words[i][8*k +: 8]);
        a = {addr[31:2], 2'b00};
        foreach (words[i]) begin
            exp_q.push_back({a, words[i]});
            a = a + 32'd4;
        end
        send_byte(SYNC);
        check("sync_clears_err", err, 0);
        check("sync_sets_hold", core_hold, 1);
        foreach (body[i]) send_byte(body[i]);
`ifdef UART_MEM_LOADER_CHECKSUM_EN
        csum = 8'h00;
        foreach (body[i]) csum ^= body[i];
        send_byte(csum_corrupt ? (csum ^ 8'h5A) : csum);
`endif
    endtask

    task automatic finish_frame(input string name, input int d0, input int l0, input int n_wr,
                                input bit exp_done, input bit exp_err);
        if (exp_done)
            for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
        repeat (40) @(negedge clk);
        check({name, "_done"}, done_cnt - d0, exp_done);
        check({name, "_err"}, err, exp_err);
        check({name, "_hold"}, core_hold, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_writes"}, log_q.size() - l0, n_wr);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic check_log(input string name, input int idx, input logic [31:0] addr, input logic [31:0] data);
        if (log_q.size() > idx) begin
            check({name, "_addr"}, log_q[idx].addr, addr);
            check({name, "_data"}, log_q[idx].data, data);
        end else begin
            check({name, "_missing"}, log_q.size(), idx + 1);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_req"}, bus_req, 0);
        check({name, "_addr"}, bus_addr, 0);
        check({name, "_wdata"}, bus_wdata, 0);
        check({name, "_we"}, bus_we, 0);
        check({name, "_hold"}, core_hold, 0);
        check({name, "_done"}, done, 0);
        check({name, "_err"}, err, 0);
        check({name, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [31:0] w[$];
        logic [31:0] a;
        int d0, l0, n;

        #1;
        check_idle_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reference frame, grant always high.
        d0 = done_cnt; l0 = log_q.size();
        w = '{32'h12345678, 32'hDEADBEEF};
        send_frame(32'h0000_1000, w);
        finish_frame("basic", d0, l0, 2, 1, 0);
        check_log("basic_w0", l0, 32'h0000_1000, 32'h12345678);
        check_log("basic_w1", l0 + 1, 32'h0000_1004, 32'hDEADBEEF);

        // Same frame, first write stalled five cycles.
        d0 = done_cnt; l0 = log_q.size();
        stall_once = 5;
        send_frame(32'h0000_1000, w);
        finish_frame("stall", d0, l0, 2, 1, 0);
        check_log("stall_w0", l0, 32'h0000_1000, 32'h12345678);
        check_log("stall_w1", l0 + 1, 32'h0000_1004, 32'hDEADBEEF);

        // Unaligned top-of-memory address wraps to zero.
        d0 = done_cnt; l0 = log_q.size();
        w = '{32'hCAFE0001, 32'hCAFE0002};
        send_frame(32'hFFFF_FFFE, w);
        finish_frame("wrap", d0, l0, 2, 1, 0);
        check_log("wrap_w0", l0, 32'hFFFF_FFFC, 32'hCAFE0001);
        check_log("wrap_w1", l0 + 1, 32'h0000_0000, 32'hCAFE0002);

        // Junk before sync, then an empty frame.
        send_byte(8'h00);
        send_byte(8'hFF);
        check("junk_err", err, 0);
        check("junk_busy", busy, 0);
        d0 = done_cnt; l0 = log_q.size();
        w.delete();
        send_frame(32'h0000_4000, w);
        finish_frame("empty", d0, l0, 0, 1, 0);

        // Framing error on the third data byte.
        d0 = done_cnt; l0 = log_q.size();
        send_byte(SYNC);
        foreach (w[i]) ;
        send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33, 1'b0);
        finish_frame("ferr", d0, l0, 0, 0, 1);

        // Next frame's sync clears the sticky error (checked inside send_frame).
        d0 = done_cnt; l0 = log_q.size();
        w = '{32'h0BADF00D};
        send_frame(32'h0000_2000, w);
        finish_frame("recover", d0, l0, 1, 1, 0);

`ifdef UART_MEM_LOADER_CHECKSUM_EN
        d0 = done_cnt; l0 = log_q.size();
        csum_corrupt = 1;
        w = '{32'h01020304, 32'h05060708};
        send_frame(32'h0000_5000, w);
        csum_corrupt = 0;
        finish_frame("bad_csum", d0, l0, 2, 0, 1);
`endif

        // Randomised frames with junk, random grant stalls and trailing bytes.
        rand_stall = 1;
        for (int f = 0; f < 5; f++) begin
            n = $urandom_range(1, 3);
            w.delete();
            for (int i = 0; i < n; i++) w.push_back($urandom);
            a = $urandom;
            repeat ($urandom_range(0, 2)) send_junk();
            d0 = done_cnt; l0 = log_q.size();
            send_frame(a, w);
            finish_frame("rand", d0, l0, n, 1, 0);
`ifndef UART_MEM_LOADER_CHECKSUM_EN
            send_junk();
            check("trail_err", err, 0);
            check("trail_busy", busy, 0);
`endif
        end
        rand_stall = 0;

        // Reset while a write is stalled: no write, everything back to zero at once.
        l0 = log_q.size();
        stall_once = 60;
        send_byte(SYNC);
        send_byte(8'h00); send_byte(8'h30); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        check("rst_test_req", bus_req, 1);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midreset_no_write", log_q.size() - l0, 0);
        check("midreset_req_after", bus_req, 0);

        // Recovery after reset.
        d0 = done_cnt; l0 = log_q.size();
        w = '{32'h600DCAFE};
        send_frame(32'h0000_8000, w);
        finish_frame("post_rst", d0, l0, 1, 1, 0);
        check_log("post_rst_w0", l0, 32'h0000_8000, 32'h600DCAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running at %0t, limit 2000000 ns", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Serial firmware loader. Receives a framed byte stream on a UART RX pin and turns it into word writes on the data-memory bus, acting as a bus initiator into the local bus.
- Holds the core off the bus while loading, so instruction and data RAMs can be reloaded without re-synthesis.
- Sits beside top_core; a bus mux selects the loader's bus signals whenever bus_gnt=1.

Parameters:
XLEN, 32, bus address/data width
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 8
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
uart_rx  input  1  serial input; idle high; asynchronous to clk
bus_req  output  1  loader requests the data bus
bus_gnt  input  1  bus granted this cycle
bus_addr  output  XLEN  write address; bits [1:0] always 0
bus_wdata  output  XLEN  write data
bus_we  output  4  byte enables; 4'hF during a write, else 4'h0
core_hold  output  1  high while a frame is in progress; external logic keeps the core in reset
done  output  1  one-cycle pulse when a frame completes successfully
err  output  1  sticky error flag
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM=IDLE; counters cleared; RX synchroniser flops set to 1.
- UART RX:
  - uart_rx passes through a 2-FF synchroniser.
  - A start bit is a 1->0 edge seen while the receiver is idle. The start bit is re-checked at CLKS_PER_BIT/2; if the line is high again it is a glitch and is ignored.
  - 8 data bits, LSB first, are sampled every CLKS_PER_BIT cycles from the mid-start-bit point, followed by the stop bit.
  - Stop bit = 0 is a framing error.
  - Each valid byte raises an internal rx_valid for exactly one cycle.
- Frame format, all fields little-endian: SYNC_BYTE, ADDR[31:0] (4 bytes), COUNT[15:0] (2 bytes), COUNT x 4 data bytes.
- FSM states:
  - IDLE: rx_valid with byte==SYNC_BYTE -> ADDR; clear err; core_hold=1. Any other byte is discarded with no error.
  - ADDR: collect 4 bytes -> LEN. Store the address with bits [1:0] forced to 0.
  - LEN: collect 2 bytes. If COUNT==0 -> FINISH, else -> DATA.
  - DATA: collect 4 bytes into the word -> WRITE.
  - WRITE: bus_req=1, bus_we=4'hF, bus_addr and bus_wdata held stable until the cycle where bus_gnt=1.
    - That cycle is the write.
    - Next cycle: bus_req=0, bus_we=0, addr+=4 (modulo 2^XLEN, so 0xFFFFFFFC -> 0), remaining-=1.
    - Then -> DATA if remaining!=0, else -> FINISH.
  - FINISH: done=1 for one cycle; core_hold=0 -> IDLE.
- bus_we is asserted only in WRITE; it is never nonzero while bus_req=0.
- Overrun: rx_valid arriving while in WRITE (grant not yet seen) -> err=1, abort.
- Abort: bus_req, bus_we and core_hold drop the next cycle -> IDLE. Words already written stay written.
- A framing error in any state other than IDLE -> err=1, abort. A framing error in IDLE is ignored.
- err stays set until the next accepted SYNC_BYTE or reset.
- done and err are never set in the same cycle.
- Reset mid-frame: immediate return to IDLE with all outputs 0. A partial word is never written.

Optional Feature:
- Macro: UART_MEM_LOADER_CHECKSUM_EN.
- Enabled:
  - One extra byte follows the data bytes; FINISH is preceded by a CSUM state.
  - The checksum is the XOR of every byte after SYNC_BYTE (address, count and data).
  - Mismatch -> err=1, no done pulse, return to IDLE.
  - A COUNT==0 frame still carries the checksum byte.
- Disabled:
  - No checksum byte; FINISH follows the last write directly.
  - A byte sent after the frame is treated as an IDLE byte.

Test Plan:
- CLKS_PER_BIT=16, gnt tied 1. Send A5, 00 10 00 00, 02 00, 78 56 34 12, EF BE AD DE -> writes 0x12345678 @0x1000 then 0xDEADBEEF @0x1004, each with bus_we=F for 1 cycle; done pulse; core_hold 0 afterwards.
- Same frame with gnt held 0 for 5 cycles during the first write -> addr, wdata and we stay stable across the stall; exactly one write per word; result unchanged.
- Address 0xFFFFFFFE, COUNT=2 -> writes at 0xFFFFFFFC, then 0x00000000.
- Junk bytes 00 FF before A5 -> ignored, err=0. COUNT=0 -> done pulse, no bus_we.
- Stop bit forced 0 on the 3rd data byte -> err=1, no write for that word, core_hold falls; next A5 clears err.
- Checksum enabled: correct XOR -> done. Wrong XOR -> err=1, no done. Also: assert rst during a write stall -> all outputs 0 immediately.
